mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (loads/stores) of the 5-stage pipeline. It sequences one outstanding transaction at a time and gives data requests priority. It drives the fetch and memory stage stalls that the hazard unit ORs into its f_stall/d_stall/e_flush logic. It discards fetch responses orphaned by a branch redirect.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits
TIMEOUT, 255, max cycles waiting for mem_rvalid (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
if_req  input  1  fetch stage wants an instruction
if_addr  input  AW  fetch address (PC)
if_kill  input  1  PC redirect (e_pc_src); in-flight fetch is stale
if_valid  output  1  one-cycle pulse: if_rdata holds a valid instruction
if_rdata  output  DW  instruction data (= mem_rdata)
f_mem_stall  output  1  fetch stage must hold
dm_req  input  1  memory stage access request
dm_we  input  1  1 = store, 0 = load
dm_addr  input  AW  data address
dm_wdata  input  DW  store data
dm_be  input  DW/8  store byte enables
dm_valid  output  1  one-cycle pulse: load data valid / store acknowledged
dm_rdata  output  DW  load data (= mem_rdata)
m_mem_stall  output  1  memory stage (and everything upstream) must hold
mem_req  output  1  request to memory
mem_we  output  1  write enable
mem_addr  output  AW  address
mem_wdata  output  DW  write data
mem_be  output  DW/8  byte enables (all ones for fetch)
mem_gnt  input  1  memory accepted the request this cycle
mem_rvalid  input  1  response/ack for the accepted request
mem_rdata  input  DW  read data
bus_err  output  1  timeout pulse (ARB_TIMEOUT_EN only)

Behaviour:
- FSM states: IDLE, WAIT_I, WAIT_D. Reset: IDLE, kill flag 0, all outputs 0.
- IDLE: mem_req = dm_req | if_req.
  - If dm_req is high, the data side is selected: mem_we/addr/wdata/be come from dm_*.
  - Otherwise the fetch side is selected: mem_we = 0, mem_addr = if_addr, mem_be = all ones, mem_wdata = 0.
- Grant: mem_req & mem_gnt moves the FSM to WAIT_D or WAIT_I. Without mem_gnt the FSM stays in IDLE and re-arbitrates every cycle; the request may switch from fetch to data before the grant.
- WAIT_*: mem_req = 0 and the mem_* address/data outputs are held. On mem_rvalid:
  - WAIT_D: dm_valid pulses 1 in the same cycle.
  - WAIT_I: if_valid pulses 1 only if the kill flag is 0.
  - Either case: the FSM returns to IDLE and the kill flag clears. Minimum access latency is 2 cycles (grant, then response); no new issue happens in the response cycle.
- Stalls (combinational):
  - m_mem_stall = dm_req & ~dm_valid.
  - f_mem_stall = if_req & ~if_valid.
- Kill flag: set when if_kill is high in WAIT_I, or in IDLE on the cycle a fetch is granted. if_kill in any other case has no effect. A killed response is consumed silently, and the redirected fetch issues from IDLE afterwards.
- mem_rvalid in IDLE is ignored (assertion: never occurs).
- Data over fetch priority cannot starve fetch: a data request only exists while a fetched instruction sits in the memory stage.
- Async reset mid-transaction: the FSM returns to IDLE immediately and pending stalls drop. The memory system is reset by the same rst_n.
- if_rdata/dm_rdata carry mem_rdata unregistered. They are meaningful only when the matching *_valid is high.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined: an 8+ bit counter clears on grant and increments each cycle in WAIT_*. On reaching TIMEOUT without mem_rvalid:
  - bus_err pulses for one cycle.
  - The pending side completes with its *_valid = 1 and rdata forced to 0. A killed fetch gives no if_valid.
  - The FSM returns to IDLE.
- Not defined: no counter; bus_err is tied 0 and TIMEOUT is unused.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, gnt at cycle 1, rvalid at cycle 3 with rdata=0x00500093 -> f_mem_stall=1 for cycles 1-2; cycle 3 gives if_valid=1, if_rdata=0x00500093, f_mem_stall=0.
- Simultaneous: if_req=1, dm_req=1 (load 0x2000) in IDLE -> mem_addr=0x2000, mem_we=0, WAIT_D; fetch issues only after dm_valid; f_mem_stall stays 1 throughout.
- Store: dm_we=1, dm_addr=0x2004, wdata=0xDEADBEEF, be=0xF -> mem_* match the inputs at grant; dm_valid on rvalid; m_mem_stall=0 that cycle.
- Kill: fetch 0x104 in WAIT_I, if_kill=1 for one cycle, then rvalid -> no if_valid; the next cycle issues the new if_addr=0x200.
- Reset mid-op: rst_n low while in WAIT_D -> IDLE, mem_req=0, both stalls 0, dm_valid never pulses.
- ARB_TIMEOUT_EN, TIMEOUT=4: grant, no rvalid -> bus_err=1 and dm_valid=1 with dm_rdata=0 on the 4th wait cycle, then IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle for the shared memory port: fetch side, data side and the memory bus.
// The master view belongs to the arbiter; the slave view is the pipeline plus memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // fetch stage
  logic              if_req;
  logic [AW-1:0]     if_addr;
  logic              if_kill;
  logic              if_valid;
  logic [DW-1:0]     if_rdata;
  logic              f_mem_stall;
  // memory stage
  logic              dm_req;
  logic              dm_we;
  logic [AW-1:0]     dm_addr;
  logic [DW-1:0]     dm_wdata;
  logic [DW/8-1:0]   dm_be;
  logic              dm_valid;
  logic [DW-1:0]     dm_rdata;
  logic              m_mem_stall;
  // memory bus
  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW/8-1:0]   mem_be;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DW-1:0]     mem_rdata;
  logic              bus_err;

  modport master (
    input  if_req, if_addr, if_kill,
    output if_valid, if_rdata, f_mem_stall,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_valid, dm_rdata, m_mem_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output bus_err
  );

  modport slave (
    output if_req, if_addr, if_kill,
    input  if_valid, if_rdata, f_mem_stall,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_valid, dm_rdata, m_mem_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter for the unified memory port, data side over fetch.
// Optional response watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.master bus
);

  localparam int BW = DW / 8;

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

  state_t          r_state;
  logic            r_kill;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [BW-1:0]   r_be;

  logic            w_idle;
  logic            w_dm;
  logic            w_if;
  logic            w_grant;
  logic            w_rsp;
  logic            w_tmo;
  logic            w_done;
  logic            w_kill_eff;
  logic            w_sel_we;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic [BW-1:0]   w_sel_be;

  // Requests are masked during reset so that every output reads 0 while rst_n is low.
  assign w_dm   = rst_n & bus.dm_req;
  assign w_if   = rst_n & bus.if_req;
  assign w_idle = (r_state == IDLE);

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    if (w_dm) begin
      w_sel_we    = bus.dm_we;
      w_sel_addr  = bus.dm_addr;
      w_sel_wdata = bus.dm_wdata;
      w_sel_be    = bus.dm_be;
    end else if (w_if) begin
      w_sel_addr  = bus.if_addr;
      w_sel_be    = '1;
    end
  end

  assign w_grant = w_idle & (w_dm | w_if) & bus.mem_gnt;
  assign w_rsp   = ~w_idle & bus.mem_rvalid;
  assign w_done  = w_rsp | w_tmo;

  // A redirect arriving in the response cycle itself already makes that instruction stale.
  assign w_kill_eff = r_kill | bus.if_kill;

  assign bus.mem_req   = w_idle & (w_dm | w_if);
  assign bus.mem_we    = w_idle ? w_sel_we    : r_we;
  assign bus.mem_addr  = w_idle ? w_sel_addr  : r_addr;
  assign bus.mem_wdata = w_idle ? w_sel_wdata : r_wdata;
  assign bus.mem_be    = w_idle ? w_sel_be    : r_be;

  assign bus.if_valid  = (r_state == WAIT_I) & w_done & ~w_kill_eff;
  assign bus.dm_valid  = (r_state == WAIT_D) & w_done;
  assign bus.if_rdata  = w_tmo ? '0 : bus.mem_rdata;
  assign bus.dm_rdata  = w_tmo ? '0 : bus.mem_rdata;

  assign bus.m_mem_stall = w_dm & ~bus.dm_valid;
  assign bus.f_mem_stall = w_if & ~bus.if_valid;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] r_cnt;

  assign w_tmo       = ~w_idle & ~bus.mem_rvalid & (r_cnt == CW'(TIMEOUT - 1));
  assign bus.bus_err = w_tmo;
`else
  assign w_tmo       = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

  // TIMEOUT below 1 has no meaningful watchdog setting; nothing is built for it.
  if (TIMEOUT < 1) begin : g_timeout_guard
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_kill  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state <= w_dm ? WAIT_D : WAIT_I;
            r_kill  <= ~w_dm & bus.if_kill;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_be    <= w_sel_be;
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        WAIT_I, WAIT_D: begin
          if (r_state == WAIT_I && bus.if_kill) begin
            r_kill <= 1'b1;
          end
`ifdef ARB_TIMEOUT_EN
          r_cnt <= r_cnt + 1'b1;
`endif
          if (w_done) begin
            r_state <= IDLE;
            r_kill  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_kill  <= 1'b0;
        end
      endcase
    end
  end

  a_no_rvalid_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_idle && bus.mem_rvalid));

endmodule
